// File: rtl/ring_mem_port.sv
// Memory-side ring snoop node: queues read/write line requests for the DDR controller and
// serialises returned lines onto RDreturn/RDdest. Define MEMPORT_PERF_EN to build rdCount/wrCount.

`ifndef RING_SLOT_ADDR
`define RING_SLOT_ADDR  4'h4
`endif
`ifndef RING_SLOT_WDATA
`define RING_SLOT_WDATA 4'h5
`endif

module ring_mem_port #(
  parameter logic [3:0] MEM_ID   = 4'd0,
  parameter int          RQ_DEPTH = 16,
  parameter int          RT_DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  RingIn,
  input  logic [3:0]   SlotTypeIn,
  input  logic [3:0]   SourceIn,
  output logic [31:0]  RDreturn,
  output logic [3:0]   RDdest,
  output logic         cmdValid,
  input  logic         cmdReady,
  output logic         cmdWrite,
  output logic [27:0]  cmdAddr,
  output logic [255:0] cmdWdata,
  input  logic         rdValid,
  output logic         rdReady,
  input  logic [255:0] rdData,
  output logic         protoErr,
  output logic         ovfErr,
  output logic [31:0]  rdCount,
  output logic [31:0]  wrCount
);

  localparam int RQ_AW = $clog2(RQ_DEPTH);
  localparam int RT_AW = $clog2(RT_DEPTH);
  localparam int RQ_W  = 1 + 28 + 256;

  typedef enum logic {RIDLE, RSEND} rstate_e;

  logic         is_addr, is_wdata;
  logic [255:0] wbuf_q;
  logic [3:0]   wcnt_q, wcnt_d, wsrc_q, wsrc_d;
  logic         wbuf_we;
  logic [2:0]   wbuf_idx;
  logic         wr_req, rd_req, proto_set, ovf_set;
  logic         protoErr_q, ovfErr_q;

  assign is_addr  = (SlotTypeIn == `RING_SLOT_ADDR);
  assign is_wdata = (SlotTypeIn == `RING_SLOT_WDATA);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wcnt_d    = wcnt_q;
    wsrc_d    = wsrc_q;
    wbuf_we   = 1'b0;
    wbuf_idx  = wcnt_q[2:0];
    wr_req    = 1'b0;
    rd_req    = 1'b0;
    proto_set = 1'b0;
    if (is_wdata) begin
      if (wcnt_q == 4'd8) begin
        proto_set = 1'b1;
      end else if (wcnt_q != 4'd0 && SourceIn != wsrc_q) begin
        // A foreign source restarts the burst with its word as word 0.
        proto_set = 1'b1;
        wbuf_we   = 1'b1;
        wbuf_idx  = 3'd0;
        wcnt_d    = 4'd1;
        wsrc_d    = SourceIn;
      end else begin
        wbuf_we = 1'b1;
        wcnt_d  = wcnt_q + 4'd1;
        if (wcnt_q == 4'd0) wsrc_d = SourceIn;
      end
    end else if (is_addr) begin
      if (RingIn[31:28] == 4'b0001) begin
        rd_req = 1'b1;
      end else if (RingIn[31:28] == 4'b0000) begin
        wcnt_d = 4'd0;
        if (wcnt_q == 4'd8 && SourceIn == wsrc_q) wr_req = 1'b1;
        else                                      proto_set = 1'b1;
      end else begin
        proto_set = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt_q     <= 4'd0;
      wsrc_q     <= 4'd0;
      protoErr_q <= 1'b0;
      ovfErr_q   <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      wsrc_q <= wsrc_d;
      if (proto_set) protoErr_q <= 1'b1;
      if (ovf_set)   ovfErr_q   <= 1'b1;
    end
  end

  // NOTE: data storage carries no reset; pointers and counts alone define validity.
  always_ff @(posedge clock) begin
    if (wbuf_we) wbuf_q[32*wbuf_idx +: 32] <= RingIn;
  end

  assign protoErr = protoErr_q;
  assign ovfErr   = ovfErr_q;

  logic [RQ_W-1:0] rq_mem [RQ_DEPTH];
  logic [3:0]      rt_mem [RT_DEPTH];
  logic [RQ_AW:0]  rq_wp_q, rq_rp_q;
  logic [RT_AW:0]  rt_wp_q, rt_rp_q;
  logic            rq_empty, rq_full, rt_empty, rt_full;
  logic            rq_pop, rq_push, rt_push, rq_room, rt_room, rd_accept;
  logic [RQ_W-1:0] rq_head;

  assign rq_empty = (rq_wp_q == rq_rp_q);
  assign rq_full  = (rq_wp_q[RQ_AW] != rq_rp_q[RQ_AW]) &&
                    (rq_wp_q[RQ_AW-1:0] == rq_rp_q[RQ_AW-1:0]);
  assign rt_empty = (rt_wp_q == rt_rp_q);
  assign rt_full  = (rt_wp_q[RT_AW] != rt_rp_q[RT_AW]) &&
                    (rt_wp_q[RT_AW-1:0] == rt_rp_q[RT_AW-1:0]);

  assign rq_pop    = cmdValid & cmdReady;
  assign rd_accept = rdValid & rdReady;
  // A pop on the same edge frees the slot, so a full FIFO still accepts then.
  assign rq_room = ~rq_full | rq_pop;
  assign rt_room = ~rt_full | rd_accept;
  assign rt_push = rd_req & rq_room & rt_room;
  assign rq_push = (wr_req & rq_room) | rt_push;
  assign ovf_set = (wr_req | rd_req) & ~rq_push;

  always_ff @(posedge clock) begin
    if (rq_push) rq_mem[rq_wp_q[RQ_AW-1:0]] <= {wr_req, RingIn[27:0], wbuf_q};
    if (rt_push) rt_mem[rt_wp_q[RT_AW-1:0]] <= SourceIn;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rq_wp_q <= '0;
      rq_rp_q <= '0;
      rt_wp_q <= '0;
      rt_rp_q <= '0;
    end else begin
      if (rq_push)   rq_wp_q <= rq_wp_q + (RQ_AW+1)'(1);
      if (rq_pop)    rq_rp_q <= rq_rp_q + (RQ_AW+1)'(1);
      if (rt_push)   rt_wp_q <= rt_wp_q + (RT_AW+1)'(1);
      if (rd_accept) rt_rp_q <= rt_rp_q + (RT_AW+1)'(1);
    end
  end

  assign rq_head  = rq_mem[rq_rp_q[RQ_AW-1:0]];
  assign cmdValid = ~rq_empty;
  assign cmdWrite = rq_head[RQ_W-1];
  assign cmdAddr  = rq_head[283:256];
  assign cmdWdata = rq_head[255:0];

  rstate_e      state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic [255:0] line_q;
  logic [3:0]   tag_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RIDLE;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clock) begin
    if (rd_accept) begin
      line_q <= rdData;
      tag_q  <= rt_mem[rt_rp_q[RT_AW-1:0]];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      RIDLE: if (rd_accept) begin
        state_d = RSEND;
        idx_d   = 3'd0;
      end
      RSEND: if (idx_q == 3'd7) begin
        state_d = rd_accept ? RSEND : RIDLE;
        idx_d   = 3'd0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
      default: state_d = RIDLE;
    endcase
  end

  always_comb begin
    rdReady  = 1'b0;
    RDreturn = 32'd0;
    RDdest   = MEM_ID;
    case (state_q)
      RIDLE: rdReady = ~rt_empty;
      RSEND: begin
        rdReady  = (idx_q == 3'd7) & ~rt_empty;
        RDreturn = line_q[32*idx_q +: 32];
        RDdest   = tag_q;
      end
      default: ;
    endcase
  end

`ifdef MEMPORT_PERF_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      if (rt_push)           rd_cnt_q <= rd_cnt_q + 32'd1;
      if (rq_push & wr_req)  wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rdCount = rd_cnt_q;
  assign wrCount = wr_cnt_q;
`else
  assign rdCount = 32'd0;
  assign wrCount = 32'd0;
`endif

endmodule

// File: tb/tb_ring_mem_port.sv
// Self-checking bench for ring_mem_port: directed scenarios plus randomized ring traffic
// compared against a queue-based reference model of requests, tags and returned words.
`timescale 1ns/1ps

`ifndef RING_SLOT_ADDR
`define RING_SLOT_ADDR  4'h4
`endif
`ifndef RING_SLOT_WDATA
`define RING_SLOT_WDATA 4'h5
`endif

module tb_ring_mem_port;

  localparam logic [3:0] MEM_ID   = 4'd0;
  localparam int         RQ_DEPTH = 16;
  localparam int         RT_DEPTH = 16;
  localparam logic [3:0] ST_EMPTY = 4'h0;
  localparam logic [3:0] ST_ADDR  = `RING_SLOT_ADDR;
  localparam logic [3:0] ST_WDATA = `RING_SLOT_WDATA;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  RingIn = '0;
  logic [3:0]   SlotTypeIn = '0, SourceIn = '0;
  logic [31:0]  RDreturn;
  logic [3:0]   RDdest;
  logic         cmdValid, cmdReady = 1'b0, cmdWrite;
  logic [27:0]  cmdAddr;
  logic [255:0] cmdWdata;
  logic         rdValid = 1'b0, rdReady;
  logic [255:0] rdData = '0;
  logic         protoErr, ovfErr;
  logic [31:0]  rdCount, wrCount;

  ring_mem_port #(.MEM_ID(MEM_ID), .RQ_DEPTH(RQ_DEPTH), .RT_DEPTH(RT_DEPTH)) dut (
    .clock(clock), .reset(reset), .RingIn(RingIn), .SlotTypeIn(SlotTypeIn),
    .SourceIn(SourceIn), .RDreturn(RDreturn), .RDdest(RDdest), .cmdValid(cmdValid),
    .cmdReady(cmdReady), .cmdWrite(cmdWrite), .cmdAddr(cmdAddr), .cmdWdata(cmdWdata),
    .rdValid(rdValid), .rdReady(rdReady), .rdData(rdData), .protoErr(protoErr),
    .ovfErr(ovfErr), .rdCount(rdCount), .wrCount(wrCount)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic         wr;
    logic [27:0]  addr;
    logic [255:0] line;
  } cmd_t;

  // Reference model state
  cmd_t         cmdq[$];
  logic [3:0]   tagq[$];
  logic [255:0] rd_pend[$];
  logic [31:0]  exp_data[$];
  logic [3:0]   exp_dest[$];
  logic [31:0]  wq[$];
  logic [3:0]   wsrc;
  logic         m_proto, m_ovf;
  logic [31:0]  m_rd_cnt, m_wr_cnt;
  logic         acc_pending;
  logic [255:0] acc_line;
  logic [3:0]   acc_tag;

  // Controller behaviour and observation logs
  int           cmd_prob = 100, rd_prob = 100;
  logic         use_seq = 1'b0;
  logic [31:0]  seq_base = '0;
  int           cmd_pops = 0;
  logic         obs_wr;
  logic [27:0]  obs_addr;
  logic [255:0] obs_wdata;
  logic [31:0]  log_data[$];
  logic [3:0]   log_dest[$];
  int           log_cyc[$];
  logic         arm_rst = 1'b0, rst_fired = 1'b0;
  logic [31:0]  rst_word;

  int n_checks = 0, n_fail = 0, cyc = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    cmdq.delete(); tagq.delete(); rd_pend.delete();
    exp_data.delete(); exp_dest.delete(); wq.delete();
    wsrc = '0; m_proto = 1'b0; m_ovf = 1'b0;
    m_rd_cnt = '0; m_wr_cnt = '0; acc_pending = 1'b0;
  endtask

  task automatic model_slot(input logic [3:0] st, input logic [31:0] d, input logic [3:0] src);
    cmd_t c;
    // Queue sizes already reflect this cycle's pops, so "< depth" means there is room.
    if (st == ST_WDATA) begin
      if (wq.size() == 8) m_proto = 1'b1;
      else if (wq.size() != 0 && src != wsrc) begin
        m_proto = 1'b1; wq.delete(); wq.push_back(d); wsrc = src;
      end else begin
        if (wq.size() == 0) wsrc = src;
        wq.push_back(d);
      end
    end else if (st == ST_ADDR) begin
      if (d[31:28] == 4'b0001) begin
        if (cmdq.size() < RQ_DEPTH && tagq.size() < RT_DEPTH) begin
          c.wr = 1'b0; c.addr = d[27:0]; c.line = '0;
          cmdq.push_back(c); tagq.push_back(src); m_rd_cnt++;
        end else m_ovf = 1'b1;
      end else if (d[31:28] == 4'b0000) begin
        if (wq.size() == 8 && src == wsrc) begin
          c.wr = 1'b1; c.addr = d[27:0];
          for (int i = 0; i < 8; i++) c.line[32*i +: 32] = wq[i];
          if (cmdq.size() < RQ_DEPTH) begin cmdq.push_back(c); m_wr_cnt++; end
          else m_ovf = 1'b1;
        end else m_proto = 1'b1;
        wq.delete();
      end else m_proto = 1'b1;
    end
  endtask

  task automatic cycle(input logic [3:0] st, input logic [31:0] d, input logic [3:0] src,
                       input logic rst);
    logic [31:0]  ed;
    logic [3:0]   edst;
    logic         rst_eff, pop_now;
    logic [255:0] ln;
    cmd_t         c;
    @(posedge clock); #1;
    cyc++;
    if (acc_pending) begin
      for (int i = 0; i < 8; i++) begin
        exp_data.push_back(acc_line[32*i +: 32]);
        exp_dest.push_back(acc_tag);
      end
      acc_pending = 1'b0;
    end
    if (exp_data.size() > 0) begin
      ed = exp_data.pop_front(); edst = exp_dest.pop_front();
    end else begin
      ed = 32'd0; edst = MEM_ID;
    end
    check("RDreturn", RDreturn, ed);
    check("RDdest", RDdest, edst);
    if (RDdest != MEM_ID) begin
      log_data.push_back(RDreturn); log_dest.push_back(RDdest); log_cyc.push_back(cyc);
    end
    check("cmdValid", cmdValid, cmdq.size() != 0);
    if (cmdValid && cmdq.size() != 0) begin
      check("cmdWrite", cmdWrite, cmdq[0].wr);
      check("cmdAddr", cmdAddr, cmdq[0].addr);
      if (cmdq[0].wr) check("cmdWdata", cmdWdata, cmdq[0].line);
    end
    check("rdReady", rdReady, exp_data.size() == 0 && tagq.size() != 0);
    check("protoErr", protoErr, m_proto);
    check("ovfErr", ovfErr, m_ovf);
`ifdef MEMPORT_PERF_EN
    check("rdCount", rdCount, m_rd_cnt);
    check("wrCount", wrCount, m_wr_cnt);
`else
    check("rdCount", rdCount, 32'd0);
    check("wrCount", wrCount, 32'd0);
`endif
    rst_eff = rst;
    if (arm_rst && exp_data.size() == 4) begin
      rst_eff = 1'b1; arm_rst = 1'b0; rst_fired = 1'b1; rst_word = RDreturn;
    end
    pop_now = 1'b0;
    if (rst_eff) begin
      cmdReady = 1'b0; rdValid = 1'b0; rdData = '0;
    end else begin
      cmdReady = ($urandom_range(99) < cmd_prob);
      pop_now  = cmdValid && cmdReady && cmdq.size() != 0;
      if (pop_now) begin
        c = cmdq.pop_front();
        cmd_pops++;
        obs_wr = cmdWrite; obs_addr = cmdAddr; obs_wdata = cmdWdata;
        if (!c.wr) begin
          for (int i = 0; i < 8; i++) ln[32*i +: 32] = use_seq ? seq_base + 32'(i) : $urandom;
          if (use_seq) seq_base += 32'd8;
          rd_pend.push_back(ln);
        end
      end
      rdValid = rd_pend.size() > 0 && ($urandom_range(99) < rd_prob);
      rdData  = rdValid ? rd_pend[0] : '0;
      if (rdValid && rdReady && tagq.size() != 0) begin
        acc_line = rd_pend.pop_front(); acc_tag = tagq.pop_front(); acc_pending = 1'b1;
      end
    end
    reset = rst_eff; SlotTypeIn = st; RingIn = d; SourceIn = src;
    if (rst_eff) model_clear();
    else model_slot(st, d, src);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(ST_EMPTY, 32'd0, 4'd0, 1'b0);
  endtask

  task automatic wdata_slot(input logic [31:0] d, input logic [3:0] src);
    cycle(ST_WDATA, d, src, 1'b0);
  endtask

  task automatic addr_slot(input logic [31:0] d, input logic [3:0] src);
    cycle(ST_ADDR, d, src, 1'b0);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((cmdq.size() != 0 || rd_pend.size() != 0 || tagq.size() != 0 ||
            exp_data.size() != 0 || acc_pending) && k < budget) begin
      idle(1);
      k++;
    end
    check("drain_timeout", k < budget, 1'b1);
    idle(1);
  endtask

  task automatic clear_log();
    log_data.delete(); log_dest.delete(); log_cyc.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic [3:0] src;
    model_clear();
    cycle(ST_EMPTY, 32'd0, 4'd0, 1'b1);
    cycle(ST_EMPTY, 32'd0, 4'd0, 1'b1);
    idle(1);
    check("rst_cmdValid", cmdValid, 1'b0);
    check("rst_RDdest", RDdest, MEM_ID);
    check("rst_rdReady", rdReady, 1'b0);

    // Write burst from source 3
    p0 = cmd_pops;
    for (int i = 0; i < 8; i++) wdata_slot(32'h100 + 32'(i), 4'd3);
    addr_slot(32'h0000_0040, 4'd3);
    drain(200);
    check("wr_count", cmd_pops - p0, 1);
    check("wr_cmdWrite", obs_wr, 1'b1);
    check("wr_cmdAddr", obs_addr, 28'h40);
    check("wr_word0", obs_wdata[31:0], 32'h100);
    check("wr_word7", obs_wdata[255:224], 32'h107);
    check("wr_protoErr", protoErr, 1'b0);

    // Single read from source 5, line words 0xA0..0xA7
    use_seq = 1'b1; seq_base = 32'hA0; clear_log();
    addr_slot(32'h1000_0080, 4'd5);
    drain(200);
    check("rd_len", log_data.size(), 8);
    for (int i = 0; i < 8 && i < log_data.size(); i++) begin
      check("rd_word", log_data[i], 32'hA0 + 32'(i));
      check("rd_dest", log_dest[i], 4'd5);
      check("rd_contig", log_cyc[i] - log_cyc[0], i);
    end
    check("rd_idle_dest", RDdest, MEM_ID);

    // Back-to-back reads from sources 2 and 6
    seq_base = 32'hB0; clear_log();
    addr_slot(32'h1000_0100, 4'd2);
    addr_slot(32'h1000_0200, 4'd6);
    drain(200);
    check("b2b_len", log_data.size(), 16);
    for (int i = 0; i < 16 && i < log_data.size(); i++) begin
      check("b2b_word", log_data[i], 32'hB0 + 32'(i));
      check("b2b_dest", log_dest[i], (i < 8) ? 4'd2 : 4'd6);
      check("b2b_contig", log_cyc[i] - log_cyc[0], i);
    end

    // Short burst is dropped, following correct burst still issues
    p0 = cmd_pops;
    for (int i = 0; i < 5; i++) wdata_slot(32'h200 + 32'(i), 4'd4);
    addr_slot(32'h0000_0080, 4'd4);
    idle(3);
    check("proto_drop", cmd_pops - p0, 0);
    check("proto_set", protoErr, 1'b1);
    for (int i = 0; i < 8; i++) wdata_slot(32'h300 + 32'(i), 4'd4);
    addr_slot(32'h0000_00C0, 4'd4);
    drain(200);
    check("proto_next", cmd_pops - p0, 1);
    check("proto_next_addr", obs_addr, 28'hC0);

    // Overflow: RQ_DEPTH+1 reads with the controller stalled
    cmd_prob = 0; clear_log();
    for (int i = 0; i <= RQ_DEPTH; i++) addr_slot({4'b0001, 28'(i + 16)}, 4'(i % 15 + 1));
    idle(2);
    check("ovf_set", ovfErr, 1'b1);
    check("ovf_cmdValid", cmdValid, 1'b1);
    check("ovf_addr_head", cmdAddr, 28'd16);
    p0 = cmd_pops;
    cmd_prob = 100;
    drain(600);
    check("ovf_cmds", cmd_pops - p0, RQ_DEPTH);
    check("ovf_words", log_data.size(), 8 * RQ_DEPTH);

    // Reset while the serialiser shows word 3
    seq_base = 32'hD0;
    addr_slot(32'h1000_0300, 4'd7);
    arm_rst = 1'b1;
    for (int k = 0; k < 100 && !rst_fired; k++) idle(1);
    check("rst_fired", rst_fired, 1'b1);
    check("rst_mid_word", rst_word, 32'hD3);
    idle(1);
    check("rst2_RDdest", RDdest, MEM_ID);
    check("rst2_cmdValid", cmdValid, 1'b0);
    check("rst2_protoErr", protoErr, 1'b0);
    check("rst2_ovfErr", ovfErr, 1'b0);
    check("rst2_rdCount", rdCount, 32'd0);
    check("rst2_wrCount", wrCount, 32'd0);
    idle(10);

    // Randomized traffic under varying controller back-pressure
    use_seq = 1'b0;
    for (int ph = 0; ph < 3; ph++) begin
      cmd_prob = (ph == 0) ? 100 : (ph == 1) ? 50 : 5;
      rd_prob  = (ph == 2) ? 30 : 70;
      for (int n = 0; n < 250; n++) begin
        src = 4'($urandom_range(15, 1));
        case ($urandom_range(9))
          0, 1, 2: addr_slot({4'b0001, 28'($urandom)}, src);
          3, 4: begin
            for (int k = 0; k < 8; k++) wdata_slot($urandom, src);
            addr_slot({4'b0000, 28'($urandom)},
                      ($urandom_range(7) == 0) ? 4'($urandom_range(15, 1)) : src);
          end
          5: wdata_slot($urandom, src);
          6: addr_slot($urandom, src);
          default: idle(1);
        endcase
      end
      cmd_prob = 100; rd_prob = 100;
      drain(3000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_mem_port.md
Name: ring_mem_port

Overview:
- Memory-side ring node that snoops the ring for memory requests and services them.
- Captures read-address slots and write-burst slots (8 WriteData words followed by a write Address) and queues them as whole-line commands to the DDR memory controller.
- Serialises each returned 256-bit read line onto the RDreturn/RDdest bus, one 32-bit word per cycle, for the requesting core (e.g. the block copier, RISC cores).
- Snoop-only: it never drives RingOut; slot nullification is done by the originating source.

Parameters:
- MEM_ID, 4'd0: value driven on RDdest when no read data is being returned; core number reserved for this port.
- RQ_DEPTH, 16: request FIFO depth in entries (power of 2).
- RT_DEPTH, 16: read-tag FIFO depth in entries (power of 2).

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high.
- RingIn  in  32  ring data.
- SlotTypeIn  in  4  ring slot type; encodings come from the shared slot-type defines.
- SourceIn  in  4  ring slot source core.
- RDreturn  out  32  read return word.
- RDdest  out  4  core that owns RDreturn this cycle; MEM_ID when idle.
- cmdValid  out  1  command to controller is valid.
- cmdReady  in  1  controller accepts the command.
- cmdWrite  out  1  1 = write, 0 = read.
- cmdAddr  out  28  line address.
- cmdWdata  out  256  write line; word 0 in [31:0].
- rdValid  in  1  read line from controller is valid.
- rdReady  out  1  port accepts the read line.
- rdData  in  256  read line; word 0 in [31:0].
- protoErr  out  1  sticky protocol error.
- ovfErr  out  1  sticky FIFO overflow.

Behaviour:
- Address slot decode: RingIn[31:28] = 4'b0001 is a read; 4'b0000 is a write; any other value sets protoErr and the slot is ignored. Line address is RingIn[27:0].
- Write capture:
  - 8x32 staging buffer plus wcnt (0..8) and wsrc.
  - A WriteData slot with wcnt < 8 stores RingIn at word wcnt and increments wcnt; on the first word wsrc is latched from SourceIn.
  - A WriteData slot from SourceIn != wsrc while wcnt != 0 sets protoErr; the word is stored as word 0, wcnt becomes 1 and wsrc becomes the new source.
  - A WriteData slot with wcnt == 8 sets protoErr and is ignored.
  - A write Address slot with wcnt == 8 and SourceIn == wsrc enqueues {write, addr, line} and clears wcnt. Otherwise it sets protoErr, is dropped, and clears wcnt.
- Read capture: a read Address slot enqueues {read, addr}. SourceIn is pushed into the read-tag FIFO in the same cycle.
- Overflow:
  - An enqueue when the request FIFO is full, or a read when the tag FIFO is full, drops that request (both FIFOs stay consistent) and sets ovfErr.
  - A full FIFO does not back-pressure the ring.
- Command issue:
  - Request FIFO is first-word-fall-through. cmdValid rises the cycle after the enqueue edge.
  - The entry pops on cmdValid & cmdReady.
  - Commands issue in ring order.
  - cmdAddr, cmdWrite and cmdWdata stay stable while cmdValid & ~cmdReady.
- Read return:
  - Serialiser states: RIDLE and RSEND (word index 0..7).
  - rdReady = (RIDLE & tag FIFO non-empty) | (RSEND & index == 7).
  - On rdValid & rdReady the line is latched and the tag popped, then RSEND begins at index 0.
  - In RSEND, each cycle drives RDreturn = word[index] and RDdest = tag, then increments index.
  - After index 7 the serialiser returns to RIDLE, or restarts at index 0 if a new line is accepted in the same cycle. Back-to-back lines give 16 contiguous words.
  - In RIDLE: RDreturn = 0, RDdest = MEM_ID.
  - Latency: rdValid accepted at edge t gives word 0 at cycle t+1 and word 7 at t+8.
  - rdValid while the tag FIFO is empty is not accepted (rdReady = 0).
- Simultaneous events: a write Address and a cmd pop in the same cycle on a full FIFO is legal, not an overflow (pop first). Ring slots are one per cycle, so captures never coincide.
- Reset (synchronous; also takes effect mid-burst or mid-return):
  - FIFOs emptied, wcnt = 0, serialiser to RIDLE.
  - Outputs: cmdValid = 0, rdReady = 0, RDreturn = 0, RDdest = MEM_ID, protoErr = 0, ovfErr = 0.
  - In-flight controller reads are discarded.

Optional Feature:
- Macro: MEMPORT_PERF_EN.
- Defined:
  - Adds outputs rdCount[31:0] and wrCount[31:0], counting accepted (non-dropped) read and write commands at enqueue.
  - Both counters wrap modulo 2^32 and are cleared by reset.
- Undefined: both outputs are present and tied to 0; no counter logic is built.

Test Plan:
- Write burst: 8 WriteData from source 3 (0x100..0x107), then Address 0x00000040 → one command with cmdWrite = 1, cmdAddr = 0x40, cmdWdata[31:0] = 0x100, [255:224] = 0x107; protoErr = 0.
- Read: Address 0x10000080 from source 5; controller returns line words 0xA0..0xA7 → RDdest = 5 for 8 consecutive cycles, RDreturn 0xA0..0xA7 in order, then RDdest = MEM_ID.
- Back-to-back: reads from sources 2 and 6, controller presents both lines consecutively → 16 contiguous words, RDdest 2 ×8 then 6 ×8, no gap cycle.
- Protocol errors: 5 WriteData then write Address → dropped, protoErr = 1; a following correct burst is still issued.
- Overflow: cmdReady = 0, issue RQ_DEPTH+1 reads → ovfErr = 1, exactly 16 commands and 16 tags; release cmdReady → 16 reads in order.
- Reset: assert mid-RSEND at index 3 → next cycle RDdest = MEM_ID, cmdValid = 0, errors cleared; with MEMPORT_PERF_EN defined, counters read 0.
